// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin arbiter granting two ports access to a single-ported data memory
module dmem_arbiter #(
    parameter int AW = 32,
    parameter int DW = 32,
    parameter int MEM_BYTES = 1024
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          m0_req,
    input  logic          m0_we,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    input  logic          m1_req,
    input  logic          m1_we,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    output logic          m0_gnt,
    output logic          m1_gnt,
    output logic          m0_rvalid,
    output logic          m1_rvalid,
    output logic          m0_err,
    output logic          m1_err,
    output logic [DW-1:0] rdata,
    output logic [AW-1:0] mem_address,
    output logic          mem_read,
    output logic          mem_write,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);
    typedef enum logic [1:0] {IDLE, ISSUE, RDWAIT, ERR} state_t;
    state_t state, state_nx;
    logic last, win, win_we, bad, any_req, we_q, port_q;
    logic [AW-1:0] win_addr;
    logic [DW-1:0] win_wdata, rdata_q;
    assign any_req   = m0_req | m1_req;
    assign win       = (m0_req & m1_req) ? ~last : m1_req;
    assign win_we    = win ? m1_we : m0_we;
    assign win_addr  = win ? m1_addr : m0_addr;
    assign win_wdata = win ? m1_wdata : m0_wdata;
    assign bad       = (|win_addr[1:0]) || (win_addr > AW'(MEM_BYTES - 4));
    always_ff @(posedge clk)
        if (!rst_n) state <= IDLE;
        else state <= state_nx;
    // memory-facing address/data only load for serviceable requests so they hold across errors
    always_ff @(posedge clk)
        if (!rst_n) begin
            last        <= 1'b1;
            we_q        <= 1'b0;
            port_q      <= 1'b0;
            mem_address <= '0;
            mem_wdata   <= '0;
            rdata_q     <= '0;
        end else begin
            if (state == IDLE && any_req) begin
                last   <= win;
                we_q   <= win_we;
                port_q <= win;
                if (!bad) begin
                    mem_address <= win_addr;
                    mem_wdata   <= win_wdata;
                end
            end
            if (state == RDWAIT) rdata_q <= mem_rdata;
        end
    always_comb
        state_nx = state == IDLE  ? (any_req ? (bad ? ERR : ISSUE) : IDLE) :
                   state == ISSUE ? (we_q ? IDLE : RDWAIT) : IDLE;
    // pulses are gated by rst_n so a reset cycle aborts the transaction immediately
    always_comb begin
        mem_write = rst_n && state == ISSUE && we_q;
        mem_read  = rst_n && state == ISSUE && !we_q;
        m0_gnt    = rst_n && (state == ISSUE || state == ERR) && !port_q;
        m1_gnt    = rst_n && (state == ISSUE || state == ERR) && port_q;
        m0_err    = rst_n && state == ERR && !port_q;
        m1_err    = rst_n && state == ERR && port_q;
        m0_rvalid = rst_n && state == RDWAIT && !port_q;
        m1_rvalid = rst_n && state == RDWAIT && port_q;
        rdata     = (rst_n && state == RDWAIT) ? mem_rdata : rdata_q;
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed checks of arbitration, latency, address errors and reset abort
module tb_dmem_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic m0_req = 1'b0, m0_we = 1'b0, m1_req = 1'b0, m1_we = 1'b0;
    logic [31:0] m0_addr = '0, m0_wdata = '0, m1_addr = '0, m1_wdata = '0;
    logic m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_err, m1_err;
    logic [31:0] rdata, mem_address, mem_wdata;
    logic mem_read, mem_write;
    logic [31:0] mem_rdata = '0;
    logic [31:0] mem [256];
    logic [255:0] written = '0;
    int n_cmp = 0, n_bad = 0;

    dmem_arbiter #(.AW(32), .DW(32), .MEM_BYTES(1024)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m0_gnt(m0_gnt), .m1_gnt(m1_gnt), .m0_rvalid(m0_rvalid), .m1_rvalid(m1_rvalid),
        .m0_err(m0_err), .m1_err(m1_err), .rdata(rdata),
        .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // memory model: unwritten words read as 0xA00000<word index>
    always @(posedge clk) begin
        if (mem_write) begin
            mem[mem_address[9:2]] <= mem_wdata;
            written[mem_address[9:2]] <= 1'b1;
        end
        if (mem_read)
            mem_rdata <= written[mem_address[9:2]] ? mem[mem_address[9:2]] : {24'hA00000, mem_address[9:2]};
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    always @(negedge clk) begin
        check("rw_excl", 64'(mem_read & mem_write), 64'd0);
        check("gnt_one", 64'(m0_gnt & m1_gnt), 64'd0);
    end

    initial begin
        tick();
        tick();
        check("rst_outs", {m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_err, m1_err, mem_read, mem_write}, 64'd0);
        check("rst_addr", mem_address, 64'd0);
        check("rst_wdata", mem_wdata, 64'd0);
        check("rst_rdata", rdata, 64'd0);
        rst_n = 1'b1;

        // m0 store then load of 0x10
        m0_req = 1; m0_we = 1; m0_addr = 32'h10; m0_wdata = 32'hDEADBEEF;
        tick();
        check("st_gnt", m0_gnt, 64'd1);
        check("st_write", {mem_write, mem_read}, 64'b10);
        check("st_addr", mem_address, 64'h10);
        check("st_wdata", mem_wdata, 64'hDEADBEEF);
        m0_req = 0;
        tick();
        check("st_idle", m0_gnt, 64'd0);
        m0_req = 1; m0_we = 0;
        tick();
        check("ld_gnt", {m0_gnt, mem_read, mem_write}, 64'b110);
        m0_req = 0;
        tick();
        check("ld_rvalid", {m0_rvalid, m1_rvalid}, 64'b10);
        check("ld_rdata", rdata, 64'hDEADBEEF);
        tick();
        check("ld_done", m0_rvalid, 64'd0);
        check("ld_hold", rdata, 64'hDEADBEEF);

        // continuous contention: m0, m1, m0, m1 every three cycles
        do_reset();
        m0_req = 1; m0_we = 0; m0_addr = 32'h20;
        m1_req = 1; m1_we = 0; m1_addr = 32'h40;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("rr_gnt", {m0_gnt, m1_gnt}, (i % 2 == 0) ? 64'b10 : 64'b01);
            tick();
            check("rr_rvalid", {m0_rvalid, m1_rvalid}, (i % 2 == 0) ? 64'b10 : 64'b01);
            check("rr_rdata", rdata, (i % 2 == 0) ? 64'hA0000008 : 64'hA0000010);
            if (i == 3) begin
                m0_req = 0;
                m1_req = 0;
            end
            tick();
            check("rr_idle", {m0_gnt, m1_gnt, m0_rvalid, m1_rvalid}, 64'd0);
        end

        // address errors, then the last valid word
        m1_req = 1; m1_addr = 32'h2;
        tick();
        check("err2_pulse", {m1_gnt, m1_err, m0_gnt, m0_err}, 64'b1100);
        check("err2_strobe", {mem_read, mem_write, m1_rvalid}, 64'd0);
        check("err2_addr", mem_address, 64'h40);
        check("err2_rdata", rdata, 64'hA0000010);
        m1_req = 0;
        tick();
        check("err2_after", {m1_gnt, m1_err, m1_rvalid}, 64'd0);
        m1_req = 1; m1_addr = 32'h3FE;
        tick();
        check("err3fe_pulse", {m1_gnt, m1_err}, 64'b11);
        check("err3fe_strobe", {mem_read, mem_write}, 64'd0);
        m1_req = 0;
        tick();
        check("err3fe_after", {m1_gnt, m1_err, m1_rvalid}, 64'd0);
        m1_req = 1; m1_addr = 32'h3FC;
        tick();
        check("ok3fc_gnt", {m1_gnt, m1_err, mem_read}, 64'b101);
        check("ok3fc_addr", mem_address, 64'h3FC);
        m1_req = 0;
        tick();
        check("ok3fc_rvalid", m1_rvalid, 64'd1);
        check("ok3fc_rdata", rdata, 64'hA00000FF);
        tick();

        // reset during RDWAIT aborts the load
        m0_req = 1; m0_we = 0; m0_addr = 32'h10;
        tick();
        check("ab_gnt", m0_gnt, 64'd1);
        m0_req = 0;
        tick();
        rst_n = 0;
        #1;
        check("ab_rvalid", m0_rvalid, 64'd0);
        tick();
        rst_n = 1;
        check("ab_outs", {m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_err, m1_err, mem_read, mem_write}, 64'd0);
        check("ab_addr", mem_address, 64'd0);
        check("ab_wdata", mem_wdata, 64'd0);
        check("ab_rdata", rdata, 64'd0);
        tick();
        check("ab_no_rvalid", m0_rvalid, 64'd0);

        // m0 store leaves the pointer favouring m1, then contention
        m0_req = 1; m0_we = 1; m0_addr = 32'h80; m0_wdata = 32'h11111111;
        tick();
        check("pre_gnt", {m0_gnt, mem_write}, 64'b11);
        m0_req = 0;
        tick();
        m0_req = 1; m0_we = 1; m0_addr = 32'h84; m0_wdata = 32'hCAFEF00D;
        m1_req = 1; m1_we = 0; m1_addr = 32'h80;
        tick();
        check("mix_n1", {m0_gnt, m1_gnt, mem_read}, 64'b011);
        m1_req = 0;
        tick();
        check("mix_n2", {m1_rvalid, m0_gnt}, 64'b10);
        check("mix_rdata", rdata, 64'h11111111);
        tick();
        check("mix_n3", {m0_gnt, m1_gnt}, 64'd0);
        tick();
        check("mix_n4", {m0_gnt, mem_write, mem_read}, 64'b110);
        check("mix_addr", mem_address, 64'h84);
        check("mix_wdata", mem_wdata, 64'hCAFEF00D);
        m0_req = 0;
        tick();
        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter AW, default 32, address width.
REQ-002 Parameter DW, default 32, data width.
REQ-003 Parameter MEM_BYTES, default 1024, size of the valid byte range of the data memory.
REQ-004 clk  input  1  the single clock; all state changes on rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 m0_req, m1_req  input  1 each  access request from port 0 (core LSU) and port 1 (debug/DMA).
REQ-007 m0_we, m1_we  input  1 each  1 = store word, 0 = load word.
REQ-008 m0_addr, m1_addr  input  AW each  byte address.
REQ-009 m0_wdata, m1_wdata  input  DW each  store data.
REQ-010 m0_gnt, m1_gnt  output  1 each  one-cycle acceptance pulse.
REQ-011 m0_rvalid, m1_rvalid  output  1 each  one-cycle load-data-valid pulse.
REQ-012 m0_err, m1_err  output  1 each  one-cycle error pulse, coincident with gnt.
REQ-013 rdata  output  DW  load data, shared by both ports, qualified by mX_rvalid.
REQ-014 mem_address  output  AW  address to the data memory.
REQ-015 mem_read, mem_write  output  1 each  data-memory strobes.
REQ-016 mem_wdata  output  DW  data-memory store data.
REQ-017 mem_rdata  input  DW  data-memory read data, valid the cycle after mem_read is sampled.

Function
REQ-018 The FSM SHALL have states IDLE, ISSUE, RDWAIT, ERR.
REQ-019 IDLE: when any req is high, select a winner, register its we/addr/wdata and port id, update the round-robin pointer, and go to ERR if the address is bad, otherwise to ISSUE; with no req, stay in IDLE.
REQ-020 Arbitration: a single requester wins; when both request, the port not granted most recently wins.
REQ-021 A bad address is addr[1:0] != 0 or addr > MEM_BYTES-4 (unsigned compare).
REQ-022 ISSUE, one cycle: drive mem_address and mem_wdata from the registers, assert mem_write (store) or mem_read (load), and pulse gnt for the winner; a store goes to IDLE, a load goes to RDWAIT.
REQ-023 RDWAIT, one cycle: rdata = mem_rdata, pulse rvalid for the winner, go to IDLE.
REQ-024 ERR, one cycle: pulse gnt and err for the winner, no memory strobe, rdata unchanged, go to IDLE.
REQ-025 Latency from first req-sampled cycle N: gnt in N+1; load rvalid in N+2; next arbitration at N+2 for a store or error, N+3 for a load.
REQ-026 A requester SHALL hold req/we/addr/wdata stable until gnt; a req still high in the cycle after gnt is treated as a new request.
REQ-027 mem_read and mem_write are never asserted together; at most one gnt, one rvalid and one err is high per cycle.
REQ-028 Memory strobes are asserted only in ISSUE; mem_address and mem_wdata hold their last value otherwise.
REQ-029 Requests arriving outside IDLE are not sampled until the FSM returns to IDLE.

Reset
REQ-030 While rst_n is low at a rising edge, the block enters IDLE and clears all outputs and address/data registers to 0; the round-robin pointer is set so that port 0 wins the first contention.
REQ-031 A reset asserted in ISSUE or RDWAIT aborts the transaction: no rvalid or gnt follows, and a store in flight is not completed by the arbiter.

Verification
REQ-032 After reset, m0 store addr 0x10 data 0xDEADBEEF, then m0 load 0x10: m0_gnt at N+1 with mem_write=1, mem_address=0x10, mem_wdata=0xDEADBEEF; later m0_rvalid=1 with rdata=0xDEADBEEF.
REQ-033 m0 and m1 both issue continuous loads: grants alternate m0, m1, m0, m1, with the first grant to m0 after reset and one transaction every 3 cycles.
REQ-034 m1 load at 0x0000_0002 and then at 0x0000_03FE (MEM_BYTES=1024): each gives m1_gnt=1 and m1_err=1 in N+1, no mem strobe and no rvalid; a load at 0x3FC is serviced normally.
REQ-035 rst_n driven low during RDWAIT of an m0 load: m0_rvalid stays 0, all outputs are 0 the next cycle, and the FSM is back in IDLE.
REQ-036 Simultaneous m0 store and m1 load with the pointer favouring m1: the m1 load completes (rvalid at N+2), then the m0 store issues with gnt at N+4, and mem_read/mem_write are never high together.
